// File: rtl/rv32i_types.sv
// Shared types and line/beat geometry for the cache side of the memory
// system; imported by the caches and by the arbiter that feeds pmem.
package rv32i_types;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_CNT_W = $clog2(BEATS);
  localparam int OFFSET_W   = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    I_DONE,
    D_DONE
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } grant_t;

  // Clears the byte-in-line offset so every burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/burst_adapter.sv
// Turns one line transfer into a BEATS-long burst on the memory bus: owns the
// line buffer, the beat counter and the beat mux (writes) / demux (reads).
module burst_adapter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_write,
  input  logic [31:0]       addr,
  input  logic [LINE_W-1:0] wline,
  output logic [31:0]       bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp,
  output logic [LINE_W-1:0] rline,
  output logic              done
);

  logic                  busy_q, busy_d;
  logic                  wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0]     line_buf_q, line_buf_d;
  logic                  beat_ok;

  assign beat_ok = busy_q && bmem_resp;
  assign done    = beat_ok && (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));

  // NOTE: every signal gets its default before the if/else so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d     = busy_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    line_buf_d = line_buf_q;
    if (start) begin
      busy_d     = 1'b1;
      wr_d       = is_write;
      addr_d     = line_align(addr);
      beat_cnt_d = '0;
      if (is_write) line_buf_d = wline;
    end else if (beat_ok) begin
      beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
      if (!wr_q) line_buf_d[BEAT_W*beat_cnt_q +: BEAT_W] = bmem_rdata;
      if (done) busy_d = 1'b0;
    end
  end

  // NOTE: the line buffer is reset as well, because the returned rdata must
  // read as zero straight out of reset; a plain storage array would not be.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      line_buf_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q     <= busy_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      line_buf_q <= line_buf_d;
    end
  end

  assign bmem_address = addr_q;
  assign bmem_read    = busy_q && !wr_q;
  assign bmem_write   = busy_q && wr_q;
  assign bmem_wdata   = bmem_write ? line_buf_q[BEAT_W*beat_cnt_q +: BEAT_W] : '0;
  assign rline        = line_buf_q;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line misses and dcache writebacks onto the single
// burst memory port and steers the completed line back to the requester.
module cache_arbiter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [31:0]       icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [31:0]       dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic [31:0]       bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic              start, start_write;
  logic [31:0]       start_addr;
  logic [LINE_W-1:0] rline;
  logic              done;
  logic              d_req, i_req, pick_d;

  assign d_req  = dcache_pmem_read || dcache_pmem_write;
  assign i_req  = icache_pmem_read;
  // On contention the cache that did not win last time goes first.
  assign pick_d = d_req && (!i_req || (last_grant_q == ICACHE));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    start        = 1'b0;
    start_write  = 1'b0;
    start_addr   = icache_pmem_address;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          start        = 1'b1;
          start_write  = dcache_pmem_write;
          start_addr   = dcache_pmem_address;
          last_grant_d = DCACHE;
          state_d      = dcache_pmem_write ? D_WR : D_RD;
        end else if (i_req) begin
          start        = 1'b1;
          last_grant_d = ICACHE;
          state_d      = I_RD;
        end
      end
      I_RD: if (done) state_d = I_DONE;
      D_RD, D_WR: if (done) state_d = D_DONE;
      I_DONE: begin
        i_rdata_d = rline;
        state_d   = IDLE;
      end
      D_DONE: begin
        d_rdata_d = rline;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= ICACHE;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  burst_adapter u_burst (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_write     (start_write),
    .addr         (start_addr),
    .wline        (dcache_pmem_wdata),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp),
    .rline        (rline),
    .done         (done)
  );

  // The live line is shown during the resp cycle; afterwards the last line held.
  assign icache_pmem_resp  = (state_q == I_DONE);
  assign dcache_pmem_resp  = (state_q == D_DONE);
  assign icache_pmem_rdata = icache_pmem_resp ? rline : i_rdata_q;
  assign dcache_pmem_rdata = dcache_pmem_resp ? rline : d_rdata_q;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Sits directly downstream of the pipeline's icache and dcache and connects them to the single physical memory port. It arbitrates cacheline misses and writebacks from the two caches. It converts each 256-bit line transfer into a 4-beat x 64-bit burst and returns whole lines to the requesting cache. It is the only master on the burst memory bus.

Parameters:
LINE_W, 256, cacheline width in bits
BEAT_W, 64, memory bus beat width in bits
BEATS, 4, beats per line (LINE_W / BEAT_W)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
icache_pmem_read  input  1  icache line read request, held until icache_pmem_resp
icache_pmem_address  input  32  icache line address
icache_pmem_rdata  output  256  returned line, valid when icache_pmem_resp=1
icache_pmem_resp  output  1  one-cycle completion pulse to icache
dcache_pmem_read  input  1  dcache line read request, held until resp
dcache_pmem_write  input  1  dcache writeback request, held until resp
dcache_pmem_address  input  32  dcache line address
dcache_pmem_wdata  input  256  writeback line
dcache_pmem_rdata  output  256  returned line, valid when dcache_pmem_resp=1
dcache_pmem_resp  output  1  one-cycle completion pulse to dcache
bmem_address  output  32  burst base address, bits[4:0] forced to 0
bmem_read  output  1  burst read, held until the last beat
bmem_write  output  1  burst write, held until the last beat
bmem_wdata  output  64  current write beat
bmem_rdata  input  64  current read beat, valid when bmem_resp=1
bmem_resp  input  1  beat accepted/valid; beats may be non-consecutive

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE; beat_cnt=0; last_grant=ICACHE.
  - Outputs: bmem_read=0, bmem_write=0, bmem_address=0, bmem_wdata=0, both resp=0, both rdata=0.
- FSM states: IDLE, I_RD, D_RD, D_WR, I_DONE, D_DONE.
- IDLE arbitration, one request per cycle:
  - dcache only: go to D_WR if dcache_pmem_write, else D_RD.
  - icache only: go to I_RD.
  - Both pending: grant the cache opposite to last_grant, so after reset the dcache wins first. last_grant updates on every grant.
  - dcache read and write asserted together is illegal; write is taken.
- Grant edge:
  - The line address is captured with bits[4:0] zeroed.
  - For D_WR, dcache_pmem_wdata is captured into a 256-bit line buffer.
  - beat_cnt is cleared.
- Burst states (I_RD, D_RD, D_WR):
  - bmem_read or bmem_write=1 and bmem_address=captured address throughout the state.
  - In D_WR, bmem_wdata = line_buf[64*beat_cnt +: 64].
  - On each bmem_resp, beat_cnt increments. In read states, bmem_rdata is written into line_buf[64*beat_cnt +: 64] (beat 0 is the lowest 64 bits).
  - On the bmem_resp with beat_cnt=3, go to the matching *_DONE state. bmem_read/bmem_write are 0 from the next cycle.
- DONE states:
  - The matching resp=1 for exactly one cycle; rdata = line_buf, then return to IDLE.
  - In D_DONE after a write, dcache_pmem_rdata = line_buf as well; its value is don't-care.
  - The cache drops its request on the same edge. A request still high in IDLE one cycle later is treated as new.
- Minimum latency: grant edge, then 4 consecutive beats, then resp. resp asserts 5 cycles after the grant edge.
  - Back-to-back requests cost 1 IDLE cycle between bursts.
- Non-resp cycles: the idle cache's resp=0 at all times. rdata holds its last value and is only meaningful while resp=1.
- Request withdrawn mid-burst (protocol violation): the burst completes and resp still pulses.
- Reset mid-burst: immediate return to IDLE on that edge; the partial line is discarded and no resp is issued.
- bmem_resp outside burst states is ignored.

Decomposition:
- Shared package rv32i_types gains:
  - arb_state_t enum
  - grant_t enum {ICACHE, DCACHE}
  - localparams LINE_W/BEAT_W/BEATS for reuse by the caches
- One sub-module, burst_adapter. It holds the line buffer, beat counter, and beat mux/demux. It takes start/is_write/addr/wline and produces bmem_* signals, rline, and done.
- cache_arbiter keeps the FSM, grant logic, and resp/rdata steering.

Test Plan:
- icache read of address 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 consecutively:
  - bmem_address=0x0000_1220
  - icache_pmem_resp pulses once 5 cycles after the grant
  - icache_pmem_rdata={0x44..44, 0x33..33, 0x22..22, 0x11..11}
- dcache write of 0x8000_0040 with wdata={D,C,B,A}:
  - bmem_write=1 for 4 beats
  - bmem_wdata sequence is A, B, C, D
  - dcache_pmem_resp pulses once; icache_pmem_resp stays 0
- Both caches request in the first cycle after reset:
  - dcache is served first; icache is granted in the IDLE cycle after dcache resp
  - a repeat of the simultaneous request alternates grants
- Read with 2 idle cycles between each bmem_resp:
  - beat_cnt holds during the gaps, the line is assembled correctly, and resp arrives 11 cycles after the grant
- rst=0 after 2 beats of a D_RD:
  - next cycle is IDLE with all outputs at reset values
  - no dcache_pmem_resp; a fresh request after reset completes normally
- dcache_pmem_read and dcache_pmem_write both high:
  - a write burst is issued, bmem_read never asserts
